pic_sync_core: RTL and testbench
================================

// Module: pic_sync_core
// PURPOSE
//  Clocked, parametrised successor of the 8259-style PIC core with a simple register bus and a two-pulse ACK handshake.
//  Provides N_IRQ request channels with per-channel edge/level trigger, mask, IRR/ISR, and fixed or rotating priority.
//  Supports specific/non-specific EOI and auto-EOI. Sits between peripheral IRQ lines and the CPU bus/interrupt input.
// PARAMETERS
//  N_IRQ    8   number of request channels; power of 2, 2..DW
//  DW       8   register/data-bus width; N_IRQ <= DW
//  AW       3   register address width (fixed map below)
// PORTS
//  clock       in   1      single clock; all state on rising edge
//  reset       in   1      synchronous, active-high; clears all state
//  wr_en       in   1      register write strobe (1 cycle)
//  rd_en       in   1      register read strobe (1 cycle)
//  addr        in   AW     register address
//  wdata       in   DW     write data
//  rdata       out  DW     read data, registered
//  rdata_valid out  1      rdata valid pulse, 1 cycle after rd_en
//  irq         in   N_IRQ  request pins, synchronous to clock
//  int_req     out  1      interrupt to CPU, registered
//  inta        in   1      acknowledge pulse from CPU (1 cycle each)
//  vector      out  DW     vector (VBASE + level, mod 2^DW)
//  vector_valid out 1      vector valid pulse
// BEHAVIOUR
//  Reset: rdata, rdata_valid, int_req, vector, vector_valid = 0; CTRL=0, MASK=all-1, TRIG=0 (edge), VBASE=0,
//    LOWEST=N_IRQ-1 (IR0 highest), IRR=ISR=0, previous-sample reg=0, FSM=IDLE. Reset wins over any same-cycle event.
//  Register map: 0 CTRL[0]=auto_eoi [1]=rotate_on_eoi [2]=enable; 1 MASK; 2 TRIG (1=level); 3 EOI (write: [7]=specific,
//    [log2N-1:0]=level; read: ISR); 4 IRR (RO); 5 ISR (RO); 6 VBASE; 7 LOWEST (lowest-priority index).
//    Unused high bits read 0; writes to RO addresses ignored. Writes take effect next cycle.
//  IRR: edge channel sets on sampled 0->1; clears on ACK1 grant of that bit or TRIG write. Same-cycle new edge beats grant.
//    Level channel: IRR bit = registered pin each cycle (except granted bit cleared on ACK1 cycle).
//  Priority: highest = (LOWEST+1) mod N_IRQ, descending cyclically. Candidate = highest-priority IRR & ~MASK bit.
//    int_req = enable && candidate exists && candidate outranks highest ISR bit (ISR empty => any candidate); registered.
//  FSM IDLE/ACK2: IDLE + inta -> ACK2; latch candidate; if present set ISR bit, clear IRR bit (edge); else spurious,
//    level = N_IRQ-1, ISR unchanged. int_req forced 0 while in ACK2.
//    ACK2 + inta -> IDLE; vector = VBASE + level, vector_valid=1 for 1 cycle; if auto_eoi clear ISR bit
//    (rotate_on_eoi: LOWEST = level). Not for spurious. No inta in ACK2: stay (no timeout).
//  EOI write: specific clears ISR[level]; non-specific clears highest-priority set ISR bit; ISR empty => no-op.
//    rotate_on_eoi => LOWEST = cleared level. EOI and auto-EOI same cycle: both clears apply, auto-EOI rotation wins.
//  Reads: rdata = reg value sampled in rd_en cycle; rd_en and wr_en same addr same cycle => old value returned.
//  Reset mid-ACK: FSM->IDLE; no vector_valid emitted.
// STRUCTURE
//  Package pic_sync_pkg: register address localparams, CTRL bit indices, FSM state typedef (IDLE, ACK2), clog2 helper.
//  One sub-module: pic_rot_prio (combinational rotating priority resolver: req[N_IRQ], lowest -> grant onehot, index, valid),
//  instanced twice (IRR candidate, ISR highest).
// TESTING
//  Reset; write MASK=0x00, CTRL=0x04; pulse irq[3] -> IRR=0x08, int_req=1 next cycle.
//  VBASE=0x40; inta, inta -> ISR=0x08, vector=0x43 + vector_valid 1 cycle; EOI 0x00 -> ISR=0x00, int_req=0.
//  irq[5] then irq[2] with ISR[5] set -> int_req rises for IR2 only; ACK gives 0x42; non-specific EOI clears bit2 first.
//  CTRL=0x07 (auto-EOI+rotate); ack IR0 -> ISR stays 0, LOWEST=0, then IR1 outranks concurrent IR0.
//  Spurious: inta with no request -> vector=VBASE+7, ISR unchanged. Level IR6 held high after EOI -> int_req reasserts.
//  Reset asserted in ACK2 -> FSM IDLE, vector_valid never pulses, all regs at reset values.

Source files
------------

// File: rtl/pic_sync_pkg.sv
// Shared definitions for the synchronous PIC core: register map, control bit
// positions, handshake FSM encoding and a constant-width helper.
package pic_sync_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_TRIG   = 3'd2;
    localparam logic [2:0] ADDR_EOI    = 3'd3;
    localparam logic [2:0] ADDR_IRR    = 3'd4;
    localparam logic [2:0] ADDR_ISR    = 3'd5;
    localparam logic [2:0] ADDR_VBASE  = 3'd6;
    localparam logic [2:0] ADDR_LOWEST = 3'd7;

    localparam int CTRL_AUTO_EOI = 0;
    localparam int CTRL_ROTATE   = 1;
    localparam int CTRL_ENABLE   = 2;
    localparam int CTRL_W        = 3;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 1'b0;
    localparam fsm_state_t ST_ACK2 = 1'b1;

    // Number of bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            rem    = rem >>> 32'd1;
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pic_rot_prio.sv
// Combinational rotating-priority resolver: the channel just above 'lowest'
// has top priority, descending cyclically down to 'lowest' itself.
module pic_rot_prio import pic_sync_pkg::*; #(
    parameter int N_IRQ = 8,
    parameter int LW    = clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req,
    input  logic [LW-1:0]    lowest,
    output logic [N_IRQ-1:0] grant,
    output logic [LW-1:0]    index,
    output logic             valid
);

    logic [N_IRQ-1:0] grant_s;
    logic [LW-1:0]    index_s;
    logic             valid_s;
    logic [LW-1:0]    idx_s;
    logic             hit_s;

    // Walk channels in priority order; the first pending one wins
    always_comb begin
        grant_s = '0;
        index_s = '0;
        valid_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= N_IRQ; i++) begin
            idx_s          = lowest + LW'(i);
            hit_s          = req[idx_s] & ~valid_s;
            grant_s[idx_s] = grant_s[idx_s] | hit_s;
            index_s        = hit_s ? idx_s : index_s;
            valid_s        = valid_s | hit_s;
        end
    end

    assign grant = grant_s;
    assign index = index_s;
    assign valid = valid_s;

endmodule

// File: rtl/pic_sync_core.sv
// Synchronous 8259-style interrupt controller core: register bus, IRR/ISR
// tracking, rotating priority and a two-pulse INTA handshake returning a vector.
module pic_sync_core import pic_sync_pkg::*; #(
    parameter int N_IRQ = 8,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata,
    output logic             rdata_valid,
    input  logic [N_IRQ-1:0] irq,
    output logic             int_req,
    input  logic             inta,
    output logic [DW-1:0]    vector,
    output logic             vector_valid
);

    localparam int               LW           = clog2(N_IRQ);
    localparam logic [LW-1:0]    LVL_SPURIOUS = LW'(N_IRQ - 32'sd1);
    localparam logic [LW-1:0]    LVL_ONE      = LW'(32'd1);
    localparam logic [N_IRQ-1:0] BIT0         = N_IRQ'(32'd1);

    // Architectural state
    logic [CTRL_W-1:0] ctrl_r;
    logic [N_IRQ-1:0]  mask_r;
    logic [N_IRQ-1:0]  trig_r;
    logic [N_IRQ-1:0]  irr_r;
    logic [N_IRQ-1:0]  isr_r;
    logic [N_IRQ-1:0]  irq_q_r;
    logic [DW-1:0]     vbase_r;
    logic [LW-1:0]     lowest_r;
    fsm_state_t        state_r;
    logic [LW-1:0]     ack_level_r;
    logic              ack_spur_r;
    logic              int_req_r;
    logic [DW-1:0]     vector_r;
    logic              vector_valid_r;
    logic [DW-1:0]     rdata_r;
    logic              rdata_valid_r;

    // Decoded strobes and next-state terms
    logic              wr_ctrl_s;
    logic              wr_mask_s;
    logic              wr_trig_s;
    logic              wr_eoi_s;
    logic              wr_vbase_s;
    logic              wr_lowest_s;
    logic              ack1_s;
    logic              ack2_s;
    logic              auto_eoi_s;
    logic [N_IRQ-1:0]  cand_req_s;
    logic [N_IRQ-1:0]  cand_grant_s;
    logic [LW-1:0]     cand_idx_s;
    logic              cand_valid_s;
    logic [N_IRQ-1:0]  isr_grant_s;
    logic [LW-1:0]     isr_idx_s;
    logic              isr_valid_s;
    logic [LW-1:0]     cand_rank_s;
    logic [LW-1:0]     isr_rank_s;
    logic [N_IRQ-1:0]  edge_s;
    logic [N_IRQ-1:0]  ack_clr_s;
    logic [N_IRQ-1:0]  auto_clr_s;
    logic [N_IRQ-1:0]  eoi_clr_s;
    logic [LW-1:0]     eoi_level_s;
    logic              eoi_rot_s;
    logic [N_IRQ-1:0]  irr_next_s;
    logic [N_IRQ-1:0]  isr_next_s;
    logic [LW-1:0]     lowest_next_s;
    fsm_state_t        state_next_s;
    logic              int_req_next_s;
    logic [DW-1:0]     rd_mux_s;

    assign wr_ctrl_s   = wr_en && (addr == AW'(ADDR_CTRL));
    assign wr_mask_s   = wr_en && (addr == AW'(ADDR_MASK));
    assign wr_trig_s   = wr_en && (addr == AW'(ADDR_TRIG));
    assign wr_eoi_s    = wr_en && (addr == AW'(ADDR_EOI));
    assign wr_vbase_s  = wr_en && (addr == AW'(ADDR_VBASE));
    assign wr_lowest_s = wr_en && (addr == AW'(ADDR_LOWEST));

    assign cand_req_s = irr_r & ~mask_r;

    pic_rot_prio #(.N_IRQ(N_IRQ), .LW(LW)) u_cand_prio (
        .req    (cand_req_s),
        .lowest (lowest_r),
        .grant  (cand_grant_s),
        .index  (cand_idx_s),
        .valid  (cand_valid_s)
    );

    pic_rot_prio #(.N_IRQ(N_IRQ), .LW(LW)) u_isr_prio (
        .req    (isr_r),
        .lowest (lowest_r),
        .grant  (isr_grant_s),
        .index  (isr_idx_s),
        .valid  (isr_valid_s)
    );

    // Rank 0 is the highest-priority position relative to the current rotation
    assign cand_rank_s = cand_idx_s - lowest_r - LVL_ONE;
    assign isr_rank_s  = isr_idx_s - lowest_r - LVL_ONE;

    assign ack1_s     = (state_r == ST_IDLE) && inta;
    assign ack2_s     = (state_r == ST_ACK2) && inta;
    assign auto_eoi_s = ack2_s && !ack_spur_r && ctrl_r[CTRL_AUTO_EOI];
    assign ack_clr_s  = (ack1_s && cand_valid_s) ? cand_grant_s : '0;
    assign auto_clr_s = auto_eoi_s ? (BIT0 << ack_level_r) : '0;
    assign edge_s     = irq & ~irq_q_r;
    assign isr_next_s = (isr_r & ~eoi_clr_s & ~auto_clr_s) | ack_clr_s;

    // Handshake FSM: first INTA latches the winner, second returns the vector
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (inta) begin
                    state_next_s = ST_ACK2;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACK2: begin
                if (inta) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK2;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // EOI command decode: specific names the level, otherwise the top ISR bit
    always_comb begin
        eoi_clr_s   = '0;
        eoi_level_s = '0;
        eoi_rot_s   = 1'b0;
        if (wr_eoi_s && wdata[DW-1]) begin
            eoi_level_s = wdata[LW-1:0];
            eoi_clr_s   = BIT0 << wdata[LW-1:0];
            eoi_rot_s   = ctrl_r[CTRL_ROTATE];
        end else if (wr_eoi_s && isr_valid_s) begin
            eoi_level_s = isr_idx_s;
            eoi_clr_s   = isr_grant_s;
            eoi_rot_s   = ctrl_r[CTRL_ROTATE];
        end else begin
            eoi_rot_s   = 1'b0;
        end
    end

    // Request register: level channels mirror the pin, edge channels latch rising edges
    always_comb begin
        irr_next_s = irr_r;
        for (int i = 0; i < N_IRQ; i++) begin
            if (trig_r[i]) begin
                irr_next_s[i] = irq[i] & ~ack_clr_s[i];
            end else if (edge_s[i]) begin
                irr_next_s[i] = 1'b1;
            end else if (ack_clr_s[i] || wr_trig_s) begin
                irr_next_s[i] = 1'b0;
            end else begin
                irr_next_s[i] = irr_r[i];
            end
        end
    end

    // Rotation source: auto-EOI rotation overrides a same-cycle EOI or register write
    always_comb begin
        lowest_next_s = lowest_r;
        if (auto_eoi_s && ctrl_r[CTRL_ROTATE]) begin
            lowest_next_s = ack_level_r;
        end else if (eoi_rot_s) begin
            lowest_next_s = eoi_level_s;
        end else if (wr_lowest_s) begin
            lowest_next_s = wdata[LW-1:0];
        end else begin
            lowest_next_s = lowest_r;
        end
    end

    // Interrupt request: enabled, unmasked candidate that outranks everything in service
    always_comb begin
        int_req_next_s = 1'b0;
        if (ctrl_r[CTRL_ENABLE] && cand_valid_s && (state_next_s == ST_IDLE)) begin
            int_req_next_s = !isr_valid_s || (cand_rank_s < isr_rank_s);
        end else begin
            int_req_next_s = 1'b0;
        end
    end

    // Register read multiplexer; unused high bits read as zero
    always_comb begin
        rd_mux_s = '0;
        case (addr)
            AW'(ADDR_CTRL):   rd_mux_s = DW'(ctrl_r);
            AW'(ADDR_MASK):   rd_mux_s = DW'(mask_r);
            AW'(ADDR_TRIG):   rd_mux_s = DW'(trig_r);
            AW'(ADDR_EOI):    rd_mux_s = DW'(isr_r);
            AW'(ADDR_IRR):    rd_mux_s = DW'(irr_r);
            AW'(ADDR_ISR):    rd_mux_s = DW'(isr_r);
            AW'(ADDR_VBASE):  rd_mux_s = vbase_r;
            AW'(ADDR_LOWEST): rd_mux_s = DW'(lowest_r);
            default:          rd_mux_s = '0;
        endcase
    end

    // State update; reset overrides every same-cycle event
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r         <= '0;
            mask_r         <= '1;
            trig_r         <= '0;
            irr_r          <= '0;
            isr_r          <= '0;
            irq_q_r        <= '0;
            vbase_r        <= '0;
            lowest_r       <= LVL_SPURIOUS;
            state_r        <= ST_IDLE;
            ack_level_r    <= '0;
            ack_spur_r     <= 1'b0;
            int_req_r      <= 1'b0;
            vector_r       <= '0;
            vector_valid_r <= 1'b0;
            rdata_r        <= '0;
            rdata_valid_r  <= 1'b0;
        end else begin
            irq_q_r  <= irq;
            irr_r    <= irr_next_s;
            isr_r    <= isr_next_s;
            lowest_r <= lowest_next_s;
            state_r  <= state_next_s;
            int_req_r <= int_req_next_s;
            if (wr_ctrl_s) begin
                ctrl_r <= wdata[CTRL_W-1:0];
            end
            if (wr_mask_s) begin
                mask_r <= wdata[N_IRQ-1:0];
            end
            if (wr_trig_s) begin
                trig_r <= wdata[N_IRQ-1:0];
            end
            if (wr_vbase_s) begin
                vbase_r <= wdata;
            end
            if (ack1_s) begin
                ack_level_r <= cand_valid_s ? cand_idx_s : LVL_SPURIOUS;
                ack_spur_r  <= !cand_valid_s;
            end
            vector_valid_r <= ack2_s;
            if (ack2_s) begin
                vector_r <= vbase_r + DW'(ack_level_r);
            end
            rdata_valid_r <= rd_en;
            if (rd_en) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    assign rdata        = rdata_r;
    assign rdata_valid  = rdata_valid_r;
    assign int_req      = int_req_r;
    assign vector       = vector_r;
    assign vector_valid = vector_valid_r;

endmodule

// File: tb/tb_pic_sync_core.sv
// Scoreboard bench for pic_sync_core: reads and vectors are queued when issued
// and compared by a monitor when the core reports them valid.
module tb_pic_sync_core;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [7:0] irq;
    logic       int_req;
    logic       inta;
    logic [7:0] vector;
    logic       vector_valid;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rd_q[$];
    logic [7:0] vec_q[$];

    pic_sync_core #(.N_IRQ(8), .DW(8), .AW(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .irq          (irq),
        .int_req      (int_req),
        .inta         (inta),
        .vector       (vector),
        .vector_valid (vector_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output monitor: pop the oldest expectation whenever the core presents a result
    always @(negedge clock) begin
        logic [7:0] exp_v;
        if (rdata_valid === 1'b1) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rdata_unexpected: got %h with no read pending", rdata);
            end else begin
                exp_v = rd_q.pop_front();
                if (rdata !== exp_v) begin
                    n_err++;
                    $display("FAIL rdata: got %h expected %h at %0t", rdata, exp_v, $time);
                end
            end
        end
        if (vector_valid === 1'b1) begin
            n_vec++;
            if (vec_q.size() == 0) begin
                n_err++;
                $display("FAIL vector_unexpected: got %h with no ack pending", vector);
            end else begin
                exp_v = vec_q.pop_front();
                if (vector !== exp_v) begin
                    n_err++;
                    $display("FAIL vector: got %h expected %h at %0t", vector, exp_v, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp_v);
        rd_q.push_back(exp_v);
        @(negedge clock);
        rd_en = 1'b1; addr = a;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        @(negedge clock);
        irq = m;
        @(negedge clock);
        irq = 8'h00;
    endtask

    task automatic ack1();
        @(negedge clock);
        inta = 1'b1;
        @(negedge clock);
        inta = 1'b0;
    endtask

    task automatic ack2(input logic [7:0] exp_v);
        vec_q.push_back(exp_v);
        @(negedge clock);
        inta = 1'b1;
        @(negedge clock);
        inta = 1'b0;
    endtask

    task automatic ack(input logic [7:0] exp_v);
        ack1();
        ack2(exp_v);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        n_vec++;
        if (int_req !== 1'b0 || vector_valid !== 1'b0 || rdata_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: int_req=%b vv=%b rv=%b expected 0 0 0", int_req, vector_valid, rdata_valid);
        end
        n_vec++;
        if (vector !== 8'h00 || rdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: vector=%h rdata=%h expected 00 00", vector, rdata);
        end
        rd(3'd0, 8'h00);
        rd(3'd1, 8'hFF);
        rd(3'd2, 8'h00);
        rd(3'd4, 8'h00);
        rd(3'd5, 8'h00);
        rd(3'd6, 8'h00);
        rd(3'd7, 8'h07);
    endtask

    task automatic test_basic();
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h04);
        pulse_irq(8'h08);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL basic_int_req_early: got %b expected 0", int_req);
        end
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL basic_int_req_rise: got %b expected 1", int_req);
        end
        rd(3'd4, 8'h08);
        wr(3'd6, 8'h40);
        ack1();
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL basic_int_req_ack2: got %b expected 0", int_req);
        end
        ack2(8'h43);
        cyc(1);
        rd(3'd5, 8'h08);
        rd(3'd4, 8'h00);
        wr(3'd3, 8'h00);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL basic_int_req_eoi: got %b expected 0", int_req);
        end
        rd(3'd5, 8'h00);
        rd(3'd3, 8'h00);
    endtask

    task automatic test_nested();
        pulse_irq(8'h20);
        cyc(1);
        ack(8'h45);
        pulse_irq(8'h40);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL nested_lower_blocked: got %b expected 0", int_req);
        end
        pulse_irq(8'h04);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL nested_higher_req: got %b expected 1", int_req);
        end
        ack(8'h42);
        rd(3'd4, 8'h40);
        rd(3'd5, 8'h24);
        wr(3'd3, 8'h00);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL nested_after_eoi1: got %b expected 0", int_req);
        end
        rd(3'd5, 8'h20);
        wr(3'd3, 8'h00);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL nested_after_eoi2: got %b expected 1", int_req);
        end
        ack(8'h46);
        wr(3'd3, 8'h86);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL nested_specific_eoi: got %b expected 0", int_req);
        end
        rd(3'd5, 8'h00);
        rd(3'd4, 8'h00);
    endtask

    task automatic test_rotate();
        wr(3'd0, 8'h07);
        pulse_irq(8'h01);
        cyc(1);
        ack(8'h40);
        rd(3'd5, 8'h00);
        rd(3'd7, 8'h00);
        pulse_irq(8'h03);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL rotate_int_req: got %b expected 1", int_req);
        end
        ack(8'h41);
        rd(3'd7, 8'h01);
        rd(3'd4, 8'h01);
        ack(8'h40);
        rd(3'd7, 8'h00);
        rd(3'd4, 8'h00);
        wr(3'd0, 8'h04);
        wr(3'd7, 8'h07);
    endtask

    task automatic test_spurious();
        rd(3'd4, 8'h00);
        ack(8'h47);
        rd(3'd5, 8'h00);
        wr(3'd1, 8'h08);
        pulse_irq(8'h08);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_masked_req: got %b expected 0", int_req);
        end
        ack(8'h47);
        rd(3'd4, 8'h08);
        rd(3'd5, 8'h00);
        wr(3'd2, 8'h00);
        rd(3'd4, 8'h00);
        wr(3'd1, 8'h00);
    endtask

    task automatic test_level();
        wr(3'd2, 8'h40);
        @(negedge clock);
        irq = 8'h40;
        cyc(2);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL level_req: got %b expected 1", int_req);
        end
        ack(8'h46);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL level_in_service: got %b expected 0", int_req);
        end
        wr(3'd3, 8'h00);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL level_reassert: got %b expected 1", int_req);
        end
        irq = 8'h00;
        cyc(2);
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL level_release: got %b expected 0", int_req);
        end
        rd(3'd4, 8'h00);
        wr(3'd2, 8'h00);
    endtask

    task automatic test_rd_wr_collision();
        rd_q.push_back(8'h40);
        @(negedge clock);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd6; wdata = 8'h55;
        @(negedge clock);
        wr_en = 1'b0; rd_en = 1'b0;
        rd(3'd6, 8'h55);
    endtask

    task automatic test_reset_mid_ack();
        pulse_irq(8'h02);
        cyc(1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL midack_req: got %b expected 1", int_req);
        end
        ack1();
        @(negedge clock);
        reset = 1'b1;
        inta  = 1'b1;
        @(negedge clock);
        inta  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        n_vec++;
        if (vector !== 8'h00 || vector_valid !== 1'b0 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL midack_outputs: vector=%h vv=%b int_req=%b expected 00 0 0", vector, vector_valid, int_req);
        end
        cyc(3);
        rd(3'd0, 8'h00);
        rd(3'd1, 8'hFF);
        rd(3'd5, 8'h00);
        rd(3'd4, 8'h00);
        rd(3'd6, 8'h00);
        rd(3'd7, 8'h07);
        ack(8'h07);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 3'd0;
        wdata = 8'h00;
        irq   = 8'h00;
        inta  = 1'b0;
        test_reset();
        test_basic();
        test_nested();
        test_rotate();
        test_spurious();
        test_level();
        test_rd_wr_collision();
        test_reset_mid_ack();
        cyc(3);
        n_vec++;
        if (rd_q.size() != 0 || vec_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: reads pending %0d vectors pending %0d expected 0 0", rd_q.size(), vec_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
